sd_io_arbiter: RTL

- Shares one host sector-IO channel between NUM virtual SD-card requesters, e.g. several SPI SD-card emulators in one core.
- Each requester exposes an lba/rd/wr/ack interface and a sector buffer.
- The arbiter grants the channel round-robin, holds the grant for one complete ack cycle, and routes ack and buffer read data.
- It sits in clk_sys between the requesters and the host IO controller.

---
 rtl/sd_arb_pkg.sv | 54 +++++
 rtl/rr_pick.sv | 36 +++
 rtl/sd_io_arbiter.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/sd_arb_pkg.sv
// ---------------------------------------------------------------------------
// sd_arb_pkg
// Shared definitions for the SD sector-IO channel arbiter:
//   - arb_state_e : arbiter transaction states
//   - dw_of/aw_of : buffer data / address widths selected by WIDE
//   - rr_next()   : rotate-and-priority-encode round-robin search
// ---------------------------------------------------------------------------
package sd_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      XFER,
      FAKE,
      RELEASE
   } arb_state_e;

   // Widest requester count the round-robin helper supports.
   localparam int RR_MAX = 8;

   // Buffer data MSB index: 8-bit or 16-bit sector buffer.
   function automatic int dw_of(input int wide);
      return (wide != 0) ? 15 : 7;
   endfunction

   // Buffer address width: 512 bytes as bytes or as 16-bit words.
   function automatic int aw_of(input int wide);
      return (wide != 0) ? 8 : 9;
   endfunction

   // Search pend starting one past last, wrapping modulo num.
   // Result is {hit, idx[2:0]}.
   function automatic logic [3:0] rr_next(input logic [RR_MAX-1:0] pend,
                                          input logic [2:0]        last,
                                          input int                num);
      logic [3:0] res;
      logic       found;
      int         j;
      res   = '0;
      found = 1'b0;
      for (int k = 1; k <= RR_MAX; k++) begin
         if (k <= num) begin
            j = int'(last) + k;
            if (j >= num) j = j - num;
            if (!found && pend[j]) begin
               found = 1'b1;
               res   = {1'b1, 3'(j)};
            end
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker for shared-channel arbiters.
// Ports:
//   pend [NUM]  pending request bits
//   last [IW]   index granted most recently (search starts at last+1)
//   hit         at least one request pending
//   idx  [IW]   index of the winning request (valid when hit)
// ---------------------------------------------------------------------------
module rr_pick
   import sd_arb_pkg::*;
#(
   parameter  int NUM = 4,
   localparam int IW  = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic [NUM-1:0] pend,
   input  logic [IW-1:0]  last,
   output logic           hit,
   output logic [IW-1:0]  idx
);

   logic [RR_MAX-1:0] pend_ext;
   logic [2:0]        last_ext;
   logic [3:0]        res;

   always_comb begin
      pend_ext           = '0;
      pend_ext[NUM-1:0]  = pend;
      last_ext           = '0;
      last_ext[IW-1:0]   = last;
      res                = rr_next(pend_ext, last_ext, NUM);
      hit                = res[3];
      idx                = res[IW-1:0];
   end

endmodule

// File: rtl/sd_io_arbiter.sv
// ---------------------------------------------------------------------------
// sd_io_arbiter
// Shares one host sector-IO channel between NUM SD-card requesters.
// Round-robin grant, held for one full ack cycle; synthesises an ack on
// host timeout so the requester's slow-domain edge detector completes.
// Ports:
//   clk_sys, reset_n          clock, async active-low reset
//   req_lba/rd/wr, req_ack    per-requester request interface
//   req_buff_din              per-requester buffer read data
//   host_lba/rd/wr, host_ack  host IO controller interface
//   host_buff_din             buffer data of the granted requester
//   busy, grant, tmo_cnt      status
// ---------------------------------------------------------------------------
module sd_io_arbiter
   import sd_arb_pkg::*;
#(
   parameter  int          NUM     = 4,
   parameter  int          WIDE    = 0,
   parameter  logic [23:0] TMO     = 24'd12_000_000,
   parameter  int          STRETCH = 8,
   localparam int          DW      = dw_of(WIDE),
   localparam int          GW      = (NUM > 1) ? $clog2(NUM) : 1
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic [NUM*32-1:0]     req_lba,
   input  logic [NUM-1:0]        req_rd,
   input  logic [NUM-1:0]        req_wr,
   output logic [NUM-1:0]        req_ack,
   input  logic [NUM*(DW+1)-1:0] req_buff_din,
   output logic [31:0]           host_lba,
   output logic                  host_rd,
   output logic                  host_wr,
   input  logic                  host_ack,
   output logic [DW:0]           host_buff_din,
   output logic                  busy,
   output logic [GW-1:0]         grant,
   output logic [7:0]            tmo_cnt
);

   // Synthetic ack: high for STRETCH cycles, then low for STRETCH cycles.
   localparam logic [23:0] STR_HI  = 24'(STRETCH - 1);
   localparam logic [23:0] STR_END = 24'(2 * STRETCH - 1);

   arb_state_e     state_q, state_d;
   logic [GW-1:0]  grant_q, grant_d;
   logic [GW-1:0]  last_q, last_d;
   logic [31:0]    lba_q, lba_d;
   logic           rd_q, rd_d;
   logic           wr_q, wr_d;
   logic [NUM-1:0] ack_q, ack_d;
   logic           busy_q, busy_d;
   logic [7:0]     tmo_q, tmo_d;
   logic [23:0]    timer_q, timer_d;   // issue timeout, fake-ack phase, release hold

   logic [NUM-1:0] pend;
   logic           pick_hit;
   logic [GW-1:0]  pick_idx;
   logic [NUM-1:0] gnt_onehot;

   assign pend       = req_rd | req_wr;
   assign gnt_onehot = {{(NUM-1){1'b0}}, 1'b1} << grant_q;

   rr_pick #(.NUM(NUM)) u_pick (
      .pend (pend),
      .last (last_q),
      .hit  (pick_hit),
      .idx  (pick_idx)
   );

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      last_d  = last_q;
      lba_d   = lba_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      ack_d   = '0;
      busy_d  = busy_q;
      tmo_d   = tmo_q;
      timer_d = timer_q;
      case (state_q)
         IDLE: begin
            if (pick_hit) begin
               grant_d = pick_idx;
               lba_d   = req_lba[32*int'(pick_idx) +: 32];
               busy_d  = 1'b1;
               rd_d    = req_rd[pick_idx];
               wr_d    = req_wr[pick_idx] & ~req_rd[pick_idx];  // read wins
               timer_d = '0;
               state_d = ISSUE;
            end
         end
         ISSUE: begin
            timer_d = timer_q + 24'd1;
            if (host_ack) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               ack_d   = gnt_onehot;
               state_d = XFER;
            end else if (timer_q == TMO - 24'd1) begin
               rd_d    = 1'b0;
               wr_d    = 1'b0;
               ack_d   = gnt_onehot;
               timer_d = '0;
               tmo_d   = (tmo_q == 8'hFF) ? tmo_q : tmo_q + 8'd1;
               state_d = FAKE;
            end
         end
         XFER: begin
            if (host_ack) begin
               ack_d = gnt_onehot;
            end else begin
               timer_d = '0;
               state_d = RELEASE;
            end
         end
         FAKE: begin
            timer_d = timer_q + 24'd1;
            if (timer_q < STR_HI) ack_d = gnt_onehot;
            if (timer_q == STR_END) begin
               timer_d = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            // Hold at least two cycles and until the requester drops its
            // level, so a stale request is never granted a second time.
            timer_d = 24'd1;
            if (timer_q != '0 && !pend[grant_q]) begin
               last_d  = grant_q;
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         last_q  <= GW'(NUM - 1);
         lba_q   <= '0;
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         ack_q   <= '0;
         busy_q  <= 1'b0;
         tmo_q   <= '0;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         lba_q   <= lba_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         ack_q   <= ack_d;
         busy_q  <= busy_d;
         tmo_q   <= tmo_d;
         timer_q <= timer_d;
      end
   end

   assign req_ack       = ack_q;
   assign host_lba      = lba_q;
   assign host_rd       = rd_q;
   assign host_wr       = wr_q;
   assign busy          = busy_q;
   assign grant         = grant_q;
   assign tmo_cnt       = tmo_q;
   assign host_buff_din = req_buff_din[(DW+1)*int'(grant_q) +: DW+1];

endmodule
